// File: rtl/vt_encoder.sv
// Sequential systematic Varshamov-Tenengolts encoder: scatters message bits into the
// non-power-of-two positions one per clock, then fills the parity positions so the checksum hits a.
module vt_encoder #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] msg_in,
  input  logic [LEN_W-1:0]      n_in,
  input  logic [LEN_W-1:0]      a_in,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] codeword_out,
  output logic [LEN_W-1:0]      k_out,
  output logic                  done,
  output logic                  err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SCATTER = 2'd1;
  localparam logic [1:0] FIX     = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] cw_q, cw_d;
  logic [DATA_WIDTH-1:0] msg_q, msg_d;
  logic [LEN_W-1:0]      nLen_q, nLen_d;
  logic [LEN_W-1:0]      aRes_q, aRes_d;
  logic [LEN_W:0]        acc_q, acc_d;
  logic [LEN_W-1:0]      pos_q, pos_d;
  logic [LEN_W-1:0]      j_q, j_d;
  logic [LEN_W-1:0]      k_q, k_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  paramsOk;
  logic                  msgBit;
  logic [LEN_W:0]        nPlus1;
  logic [LEN_W:0]        accSum;
  logic [LEN_W:0]        accWrap;
  logic [LEN_W:0]        dVal;
  logic [LEN_W:0]        aWide;

  function automatic logic isPow2(input logic [LEN_W-1:0] v);
    return (v != '0) && ((v & (v - LEN_W'(1))) == '0);
  endfunction

  // k = n minus the number of parity positions, which equals the bit length of n.
  function automatic logic [LEN_W-1:0] calcK(input logic [LEN_W-1:0] n);
    logic [LEN_W-1:0] p;
    p = '0;
    for (int b = 0; b < LEN_W; b++) begin
      if (n[b]) p = LEN_W'(b + 1);
    end
    return n - p;
  endfunction

  assign paramsOk = (n_in >= LEN_W'(3)) && (n_in <= LEN_W'(DATA_WIDTH)) && (a_in <= n_in);

  always_comb begin
    state_d = state_q;
    cw_d    = cw_q;
    msg_d   = msg_q;
    nLen_d  = nLen_q;
    aRes_d  = aRes_q;
    acc_d   = acc_q;
    pos_d   = pos_q;
    j_d     = j_q;
    k_d     = k_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    msgBit = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (j_q == LEN_W'(i)) msgBit = msg_q[i];
    end

    // acc stays in 0..n, so one conditional subtract is enough to reduce mod n+1.
    nPlus1  = {1'b0, nLen_q} + (LEN_W+1)'(1);
    aWide   = {1'b0, aRes_q};
    accSum  = acc_q + {1'b0, pos_q};
    accWrap = (accSum >= nPlus1) ? (accSum - nPlus1) : accSum;
    dVal    = (aWide >= acc_q) ? (aWide - acc_q) : (aWide + nPlus1 - acc_q);

    case (state_q)
      IDLE: begin
        if (start) begin
          if (paramsOk) begin
            msg_d   = msg_in;
            nLen_d  = n_in;
            aRes_d  = a_in;
            cw_d    = '0;
            acc_d   = '0;
            pos_d   = LEN_W'(1);
            j_d     = '0;
            k_d     = calcK(n_in);
            state_d = SCATTER;
          end else begin
            cw_d   = '0;
            k_d    = '0;
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end
      SCATTER: begin
        for (int i = 0; i < DATA_WIDTH; i++) begin
          if (pos_q == LEN_W'(i + 1)) cw_d[i] = isPow2(pos_q) ? 1'b0 : msgBit;
        end
        if (!isPow2(pos_q)) begin
          j_d = j_q + LEN_W'(1);
          if (msgBit) acc_d = accWrap;
        end
        pos_d = pos_q + LEN_W'(1);
        if (pos_q == nLen_q) state_d = FIX;
      end
      FIX: begin
        // Parity bit at position 2^b carries bit b of the checksum deficit.
        for (int i = 0; i < DATA_WIDTH; i++) begin
          for (int b = 0; b <= LEN_W; b++) begin
            if ((1 << b) == (i + 1)) cw_d[i] = dVal[b];
          end
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cw_q    <= '0;
      msg_q   <= '0;
      nLen_q  <= '0;
      aRes_q  <= '0;
      acc_q   <= '0;
      pos_q   <= '0;
      j_q     <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cw_q    <= cw_d;
      msg_q   <= msg_d;
      nLen_q  <= nLen_d;
      aRes_q  <= aRes_d;
      acc_q   <= acc_d;
      pos_q   <= pos_d;
      j_q     <= j_d;
      k_q     <= k_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign codeword_out = cw_q;
  assign k_out        = k_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_vt_encoder.sv
// Bench for vt_encoder: directed cases plus a random sweep checked against a
// behavioural VT model and the checksum / data-placement invariants.
module tb_vt_encoder;

  localparam int DW = 32;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] msg_in = '0;
  logic [LW-1:0] n_in = '0;
  logic [LW-1:0] a_in = '0;
  logic          busy;
  logic [DW-1:0] codeword_out;
  logic [LW-1:0] k_out;
  logic          done;
  logic          err;

  int checks = 0;
  int failures = 0;

  vt_encoder #(.DATA_WIDTH(DW), .LEN_W(LW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .msg_in(msg_in),
    .n_in(n_in),
    .a_in(a_in),
    .busy(busy),
    .codeword_out(codeword_out),
    .k_out(k_out),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  function automatic int refK(input int n);
    return n - $clog2(n + 1);
  endfunction

  // Build the codeword position by position, then fix the parity positions from the deficit.
  function automatic logic [31:0] refCode(input int n, input int a, input logic [31:0] msg);
    int c[0:32];
    int j;
    int s;
    int d;
    logic [31:0] r;
    j = 0;
    s = 0;
    r = '0;
    for (int p = 0; p <= 32; p++) c[p] = 0;
    for (int p = 1; p <= n; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p] = int'(msg[j]);
        j++;
      end
      s += p * c[p];
    end
    d = (((a - s) % (n + 1)) + (n + 1)) % (n + 1);
    for (int b = 0; (1 << b) <= n; b++) c[1 << b] = (d >> b) & 1;
    for (int p = 1; p <= n; p++) r[p-1] = c[p][0];
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int n, input int a, input logic [31:0] msg);
    msg_in = msg;
    n_in   = LW'(n);
    a_in   = LW'(a);
    start  = 1'b1;
  endtask

  // Returns at the falling edge where done is seen; lat counts edges after the sampling edge.
  task automatic waitDone(input int disturbAt, output int lat, output logic busy0);
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    busy0 = busy;
    while (done !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
      if (lat == disturbAt) begin
        start  = 1'b1;
        msg_in = $urandom;
        n_in   = LW'(9);
        a_in   = LW'(2);
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic runValid(input int n, input int a, input logic [31:0] msg, input int disturbAt);
    int lat;
    logic busy0;
    int s;
    int j;
    logic [31:0] dataBits;
    logic [31:0] mask;
    applyStimulus(n, a, msg);
    waitDone(disturbAt, lat, busy0);
    checkOutput($sformatf("latency n=%0d", n), 64'(lat), 64'(n + 1));
    checkOutput($sformatf("busy after start n=%0d", n), 64'(busy0), 64'(1));
    checkOutput($sformatf("busy at done n=%0d", n), 64'(busy), 64'(0));
    checkOutput($sformatf("err n=%0d", n), 64'(err), 64'(0));
    checkOutput($sformatf("codeword n=%0d a=%0d", n, a), 64'(codeword_out), 64'(refCode(n, a, msg)));
    checkOutput($sformatf("k n=%0d", n), 64'(k_out), 64'(refK(n)));
    s = 0;
    j = 0;
    dataBits = '0;
    for (int p = 1; p <= n; p++) begin
      s += p * int'(codeword_out[p-1]);
      if ((p & (p - 1)) != 0) begin
        dataBits[j] = codeword_out[p-1];
        j++;
      end
    end
    mask = (j >= 32) ? 32'hFFFF_FFFF : ((32'd1 << j) - 32'd1);
    checkOutput($sformatf("checksum n=%0d", n), 64'(s % (n + 1)), 64'(a));
    checkOutput($sformatf("data bits n=%0d", n), 64'(dataBits), 64'(msg & mask));
    checkOutput($sformatf("high bits n=%0d", n), 64'(codeword_out >> n), 64'(0));
  endtask

  task automatic runInvalid(input int n, input int a);
    applyStimulus(n, a, 32'hFFFF_FFFF);
    @(negedge clk);
    start = 1'b0;
    checkOutput($sformatf("invalid done n=%0d a=%0d", n, a), 64'(done), 64'(1));
    checkOutput($sformatf("invalid err n=%0d a=%0d", n, a), 64'(err), 64'(1));
    checkOutput($sformatf("invalid codeword n=%0d", n), 64'(codeword_out), 64'(0));
    checkOutput($sformatf("invalid k n=%0d", n), 64'(k_out), 64'(0));
    checkOutput($sformatf("invalid busy n=%0d", n), 64'(busy), 64'(0));
    @(negedge clk);
    checkOutput($sformatf("invalid done pulse n=%0d", n), 64'(done), 64'(0));
    checkOutput($sformatf("invalid busy later n=%0d", n), 64'(busy), 64'(0));
  endtask

  initial begin
    int n;
    int a;
    logic [31:0] m;
    logic sawDone;
    logic [31:0] held;

    repeat (2) @(negedge clk);
    checkOutput("reset busy", 64'(busy), 64'(0));
    checkOutput("reset done", 64'(done), 64'(0));
    checkOutput("reset err", 64'(err), 64'(0));
    checkOutput("reset codeword", 64'(codeword_out), 64'(0));
    checkOutput("reset k", 64'(k_out), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    runValid(4, 0, 32'h1, -1);
    checkOutput("n4 codeword const", 64'(codeword_out), 64'h6);
    checkOutput("n4 k const", 64'(k_out), 64'(1));
    held = codeword_out;
    @(negedge clk);
    checkOutput("done single pulse", 64'(done), 64'(0));
    repeat (2) @(negedge clk);
    checkOutput("codeword hold", 64'(codeword_out), 64'(held));

    runValid(7, 0, 32'hB, -1);
    checkOutput("n7 a0 const", 64'(codeword_out), 64'h55);
    runValid(7, 3, 32'hB, -1);
    checkOutput("n7 a3 back-to-back", 64'(codeword_out), 64'h5C);

    runInvalid(2, 0);
    runInvalid(7, 8);
    runInvalid(DW + 1, 0);

    for (int it = 0; it < 40; it++) begin
      n = int'($urandom_range(3, DW));
      a = int'($urandom_range(0, n));
      m = $urandom;
      runValid(n, a, m, -1);
    end
    runValid(DW, DW, 32'hFFFF_FFFF, -1);
    runValid(3, 3, 32'h0, -1);

    runValid(20, 11, $urandom, 3);
    @(negedge clk);

    applyStimulus(32, 5, $urandom);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy", 64'(busy), 64'(0));
    checkOutput("abort done", 64'(done), 64'(0));
    checkOutput("abort codeword", 64'(codeword_out), 64'(0));
    checkOutput("abort k", 64'(k_out), 64'(0));
    sawDone = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) sawDone = 1'b1;
    end
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done) sawDone = 1'b1;
    end
    checkOutput("no done after abort", 64'(sawDone), 64'(0));
    runValid(32, 17, $urandom, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
